pixel_scanner: RTL and testbench

PIXEL_SCANNER -- requirements
Module: pixel_scanner

---
 rtl/pixel_scanner.sv | 176 +++++++++++++++++
 tb/tb_pixel_scanner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scanner.sv
// pixel_scanner: time-multiplexed digit scanner with per-digit enable and
// PWM-style dimming. A prescaler produces one scan tick every TICK_DIV
// clocks. Each enabled digit owns a slot of 2^DIM_BITS ticks. The first tick
// of a slot is always dark, so segment data can settle before the anode is
// driven. After that the anode stays lit while the slot position is at or
// below the live brightness value.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no digit enabled; anodes off, sel = 0, waiting for a mask bit
// BLANK | slot tick 0 of the current digit; anodes off (ghosting guard)
// ON    | current digit's anode driven low
// OFF   | remainder of the slot after the lit portion; anodes off

module pixel_scanner #(
   parameter  int NUM_DIGITS = 8,
   parameter  int TICK_DIV   = 100000,
   parameter  int DIM_BITS   = 3,
   localparam int SEL_W      = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_DIGITS-1:0] en_mask,
   input  logic [DIM_BITS-1:0]   brightness,
   output logic [NUM_DIGITS-1:0] a,
   output logic [SEL_W-1:0]      sel,
   output logic                  frame_start
);

   localparam int                PRE_W     = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [DIM_BITS-1:0] SLOT_LAST = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2,
      ST_OFF   = 2'd3
   } state_t;

   logic [PRE_W-1:0]    r_presc;
   state_t              r_state;
   logic [SEL_W-1:0]    r_digit;
   logic [DIM_BITS-1:0] r_slot;
   logic                r_frame;

   logic                w_tick;
   logic                w_any;
   logic [SEL_W-1:0]    w_lowest;
   logic                w_found_above;
   logic [SEL_W-1:0]    w_above;
   logic [DIM_BITS-1:0] w_slot_inc;

   state_t              w_state_nx;
   logic [SEL_W-1:0]    w_digit_nx;
   logic [DIM_BITS-1:0] w_slot_nx;
   logic                w_frame_nx;

   assign w_tick     = (r_presc == PRE_LAST);
   assign w_slot_inc = r_slot + 1'b1;

   // Prescaler: free-running 0..TICK_DIV-1, restarts from 0 on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   // Lowest enabled digit, and the nearest enabled digit above the current one.
   // Both loops run high-to-low so the last hit is the smallest qualifying index.
   always_comb begin
      w_any         = 1'b0;
      w_lowest      = '0;
      w_found_above = 1'b0;
      w_above       = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (en_mask[i]) begin
            w_any    = 1'b1;
            w_lowest = SEL_W'(i);
         end
      end
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (en_mask[i] && (i > int'(r_digit))) begin
            w_found_above = 1'b1;
            w_above       = SEL_W'(i);
         end
      end
   end

   // Next-state logic: everything moves on tick only. Slot end beats the
   // ON->OFF decision. A frame starts whenever the digit index wraps.
   always_comb begin
      w_state_nx = r_state;
      w_digit_nx = r_digit;
      w_slot_nx  = r_slot;
      w_frame_nx = 1'b0;
      if (w_tick) begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  w_state_nx = ST_BLANK;
                  w_digit_nx = w_lowest;
                  w_slot_nx  = '0;
                  w_frame_nx = 1'b1;
               end
            end
            ST_BLANK: begin
               w_slot_nx  = DIM_BITS'(1);
               w_state_nx = (brightness != '0) ? ST_ON : ST_OFF;
            end
            ST_ON, ST_OFF: begin
               if (r_slot == SLOT_LAST) begin
                  w_slot_nx = '0;
                  if (!w_any) begin
                     w_state_nx = ST_IDLE;
                     w_digit_nx = '0;
                  end else begin
                     w_state_nx = ST_BLANK;
                     if (w_found_above) begin
                        w_digit_nx = w_above;
                     end else begin
                        w_digit_nx = w_lowest;
                        w_frame_nx = 1'b1;
                     end
                  end
               end else begin
                  w_slot_nx = w_slot_inc;
                  if ((r_state == ST_ON) && (w_slot_inc > brightness)) begin
                     w_state_nx = ST_OFF;
                  end
               end
            end
            default: begin
               w_state_nx = ST_IDLE;
               w_digit_nx = '0;
               w_slot_nx  = '0;
            end
         endcase
      end
   end

   // State, digit, slot and frame-pulse registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_digit <= '0;
         r_slot  <= '0;
         r_frame <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_digit <= w_digit_nx;
         r_slot  <= w_slot_nx;
         r_frame <= w_frame_nx;
      end
   end

   // Moore output decode: only one anode can ever be low, and only in ON.
   always_comb begin
      a = '1;
      if (r_state == ST_ON) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (SEL_W'(i) == r_digit) begin
               a[i] = 1'b0;
            end
         end
      end
   end

   assign sel         = r_digit;
   assign frame_start = r_frame;

endmodule

// File: tb/tb_pixel_scanner.sv
// Bench for pixel_scanner (4 digits, tick every 2 clks, 2-bit dimming).
// A tick-level reference model tracks which digit owns the slot, the tick
// position inside the slot and whether the anode is still lit.
module tb_pixel_scanner;

   localparam int ND         = 4;
   localparam int TD         = 2;
   localparam int DB         = 2;
   localparam int SLOT_TICKS = 1 << DB;

   logic          clk = 1'b0;
   logic          reset;
   logic [ND-1:0] en_mask;
   logic [DB-1:0] brightness;
   logic [ND-1:0] a;
   logic [1:0]    sel;
   logic          frame_start;

   always #5 clk = ~clk;

   pixel_scanner #(
      .NUM_DIGITS (ND),
      .TICK_DIV   (TD),
      .DIM_BITS   (DB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .en_mask     (en_mask),
      .brightness  (brightness),
      .a           (a),
      .sel         (sel),
      .frame_start (frame_start)
   );

   // At most one anode low in any cycle.
   assert property (@(posedge clk) $countones(~a) <= 1)
      else $error("FAIL onehot_assert a=%b", a);

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference model state
   int m_cnt    = 0;
   int m_digit  = 0;
   int m_pos    = 0;
   bit m_active = 1'b0;
   bit m_lit    = 1'b0;
   bit m_frame  = 1'b0;

   int cycle_no = 0;
   int f_prev   = -1;
   int f_last   = -1;

   function automatic int lowest_set(input logic [ND-1:0] msk);
      for (int k = 0; k < ND; k++) begin
         if (msk[k]) return k;
      end
      return 0;
   endfunction

   task automatic model_step(input bit rst, input logic [ND-1:0] msk, input int br);
      bit tick;
      int nxt;
      if (rst) begin
         m_cnt = 0; m_active = 0; m_digit = 0; m_pos = 0; m_lit = 0; m_frame = 0;
      end else begin
         tick    = (m_cnt == TD - 1);
         m_cnt   = (m_cnt + 1) % TD;
         m_frame = 0;
         if (tick) begin
            if (!m_active) begin
               if (msk != 0) begin
                  m_active = 1; m_digit = lowest_set(msk); m_pos = 0; m_lit = 0; m_frame = 1;
               end
            end else if (m_pos == SLOT_TICKS - 1) begin
               if (msk == 0) begin
                  m_active = 0; m_digit = 0; m_pos = 0; m_lit = 0;
               end else begin
                  nxt = m_digit;
                  for (int k = 1; k <= ND; k++) begin
                     if (msk[(m_digit + k) % ND]) begin
                        nxt = (m_digit + k) % ND;
                        break;
                     end
                  end
                  m_frame = (nxt <= m_digit);
                  m_digit = nxt;
                  m_pos   = 0;
                  m_lit   = 0;
               end
            end else begin
               m_pos = m_pos + 1;
               m_lit = ((m_pos == 1) || m_lit) && (br >= m_pos);
            end
         end
      end
   endtask

   function automatic logic [ND-1:0] exp_a();
      logic [ND-1:0] v;
      v = '1;
      if (m_active && m_lit) v[m_digit] = 1'b0;
      return v;
   endfunction

   // Drive one clock with the given inputs and check all outputs after the edge.
   task automatic cyc(input bit rst, input logic [ND-1:0] msk, input logic [DB-1:0] br);
      reset      = rst;
      en_mask    = msk;
      brightness = br;
      model_step(rst, msk, int'(br));
      @(posedge clk);
      #1;
      cycle_no++;
      chk("a", 32'(a), 32'(exp_a()));
      chk("sel", 32'(sel), 32'(m_digit));
      chk("frame_start", 32'(frame_start), 32'(m_frame));
      chk("onehot", 32'($countones(~a) <= 1), 32'd1);
      if (frame_start) begin
         f_prev = f_last;
         f_last = cycle_no;
      end
   endtask

   initial begin
      logic [ND-1:0] r_msk;
      logic [DB-1:0] r_br;
      bit            r_rst;
      int            bad_lit;

      reset = 1'b1; en_mask = '0; brightness = '0;
      repeat (3) cyc(1, 4'b0000, 2'd0);
      chk("rst_a", 32'(a), 32'hF);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_fs", 32'(frame_start), 32'd0);

      // full scan, full brightness
      f_prev = -1; f_last = -1;
      repeat (80) cyc(0, 4'b1111, 2'd3);
      chk("frame_period_1111", 32'(f_last - f_prev), 32'(4 * SLOT_TICKS * TD));

      // dimming
      repeat (40) cyc(0, 4'b1111, 2'd1);
      repeat (40) cyc(0, 4'b1111, 2'd0);

      // digit skipping
      f_prev = -1; f_last = -1; bad_lit = 0;
      for (int i = 0; i < 80; i++) begin
         cyc(0, 4'b1010, 2'd3);
         if (a[0] == 1'b0 || a[2] == 1'b0) bad_lit++;
      end
      chk("skip_dark_0_2", 32'(bad_lit), 32'd0);
      chk("frame_period_1010", 32'(f_last - f_prev), 32'(2 * SLOT_TICKS * TD));

      // mask removed mid-slot on digit 2, then restored to digit 2 only
      begin
         int n;
         n = 0;
         while (!(sel == 2'd2) && n < 100) begin cyc(0, 4'b1111, 2'd3); n++; end
         chk("reach_sel2", 32'(sel), 32'd2);
         cyc(0, 4'b1111, 2'd3);
         repeat (20) cyc(0, 4'b0000, 2'd3);
         chk("idle_a", 32'(a), 32'hF);
         chk("idle_sel", 32'(sel), 32'd0);
         n = 0;
         do begin cyc(0, 4'b0100, 2'd3); n++; end while (!frame_start && n < 8);
         chk("restore_fs", 32'(frame_start), 32'd1);
         chk("restore_sel", 32'(sel), 32'd2);
         repeat (20) cyc(0, 4'b0100, 2'd2);
      end

      // reset during ON of digit 3
      begin
         int n;
         n = 0;
         while (!(sel == 2'd3 && a[3] == 1'b0) && n < 100) begin cyc(0, 4'b1111, 2'd3); n++; end
         chk("reach_on3", 32'(sel == 2'd3 && a[3] == 1'b0), 32'd1);
         cyc(1, 4'b1111, 2'd3);
         chk("midrst_a", 32'(a), 32'hF);
         chk("midrst_sel", 32'(sel), 32'd0);
         chk("midrst_fs", 32'(frame_start), 32'd0);
         cyc(0, 4'b1110, 2'd3);
         cyc(0, 4'b1110, 2'd3);
         chk("restart_sel", 32'(sel), 32'd1);
         chk("restart_fs", 32'(frame_start), 32'd1);
         repeat (30) cyc(0, 4'b1110, 2'd3);
      end

      // random mask / brightness / occasional reset
      r_msk = 4'($urandom);
      r_br  = 2'($urandom);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) r_msk = 4'($urandom);
         if ($urandom_range(0, 9) == 0)  r_br  = 2'($urandom);
         r_rst = ($urandom_range(0, 399) == 0);
         cyc(r_rst, r_msk, r_br);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
